// File: rtl/store_serializer.sv
// store_serializer: narrows a 32-bit store into byte beats on an 8-bit
// data-memory write port. Little-endian: byte k of the data goes to base+k.
//
// Ports:
//   CLK, Reset          clock, asynchronous active-high reset
//   req_valid/req_ready store request handshake (ready only while idle)
//   req_addr/data/size  store byte address, data, size (00 B, 01 H, 10 W, 11 illegal)
//   mem_we/addr/wdata   one byte write per beat, held until mem_ack
//   mem_ack             memory accepts the current beat at this edge
//   done                one-cycle pulse after the last beat is accepted
//   err                 one-cycle pulse for a misaligned or illegal request
module store_serializer #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t              state;
    logic [1:0]          idx;
    logic [ADDR_W-1:0]   base;
    logic [DATA_W-1:0]   data;
    logic [1:0]          size;

    logic                req_ok;
    logic [1:0]          last_idx;
    logic [1:0]          next_idx;

    // Alignment / legality of the incoming request
    always_comb begin
        req_ok = 1'b1;
        case (req_size)
            2'b00:   req_ok = 1'b1;
            2'b01:   req_ok = ~req_addr[0];
            2'b10:   req_ok = (req_addr[1:0] == 2'b00);
            default: req_ok = 1'b0;
        endcase
    end

    // Index of the final beat for the latched size
    always_comb begin
        last_idx = 2'd3;
        case (size)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    assign next_idx = idx + 2'd1;

    // Control FSM; every output is a register loaded one edge ahead
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            base      <= '0;
            data      <= '0;
            size      <= 2'd0;
            req_ready <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        base      <= req_addr;
                        data      <= req_data;
                        size      <= req_size;
                        idx       <= 2'd0;
                        req_ready <= 1'b0;
                        if (req_ok) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_data[7:0];
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        if (idx == last_idx) begin
                            state     <= DONE;
                            idx       <= 2'd0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= 8'd0;
                            done      <= 1'b1;
                        end else begin
                            idx       <= next_idx;
                            mem_addr  <= base + ADDR_W'(next_idx);
                            mem_wdata <= data[{next_idx, 3'b000} +: 8];
                        end
                    end
                end
                DONE, ERR: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
